// File: rtl/serializer_pkg.sv
// Shared types and the lane-selection helper for the AXI-Stream lane serializer.
package serializer_pkg;

    localparam int MAX_WORD_W = 1024;

    typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} lane_order_e;
    typedef enum logic {TLAST_COUNT = 1'b0, TLAST_FORWARD = 1'b1} tlast_mode_e;

    // Returns the word shifted so that the requested lane sits in the LSBs.
    function automatic logic [MAX_WORD_W-1:0] lane_select(
        input logic [MAX_WORD_W-1:0] word,
        input int                    idx,
        input int                    lanes,
        input int                    sample_w,
        input lane_order_e           order
    );
        int lane;
        lane = (order == MSB_FIRST) ? (lanes - 1 - idx) : idx;
        return word >> (lane * sample_w);
    endfunction

endpackage

// File: rtl/axis_lane_serializer.sv
// Splits each wide AXIS beat into LANES single-sample beats, with packet and stall counters.
// Latency: one cycle from input accept to first output sample; zero-bubble reload between beats.
// Backpressure: input ready only when idle or when the last lane handshakes; stalls hold tdata/tlast.
module axis_lane_serializer
    import serializer_pkg::*;
#(
    parameter int IN_WIDTH       = 192,
    parameter int SAMPLE_WIDTH   = 16,
    parameter int PACKET_SAMPLES = 6144,
    parameter int LANE_ORDER     = 0,
    parameter int TLAST_MODE     = 0
) (
    input  logic                      s00_axis_aclk,
    input  logic                      s00_axis_aresetn,
    input  logic                      s00_axis_tvalid,
    output logic                      s00_axis_tready,
    input  logic [IN_WIDTH-1:0]       s00_axis_tdata,
    input  logic                      s00_axis_tlast,
    output logic                      m00_axis_tvalid,
    input  logic                      m00_axis_tready,
    output logic [SAMPLE_WIDTH-1:0]   m00_axis_tdata,
    output logic [SAMPLE_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                      m00_axis_tlast,
    output logic [15:0]               packet_count,
    output logic [15:0]               stall_count
);

    localparam int LANES  = IN_WIDTH / SAMPLE_WIDTH;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CNT_W  = (PACKET_SAMPLES > 1) ? $clog2(PACKET_SAMPLES) : 1;
    localparam logic [LIDX_W-1:0] LAST_LANE   = LIDX_W'(LANES - 1);
    localparam logic [CNT_W-1:0]  LAST_SAMPLE = CNT_W'(PACKET_SAMPLES - 1);
    localparam lane_order_e ORDER = (LANE_ORDER != 0) ? MSB_FIRST : LSB_FIRST;
    localparam tlast_mode_e TMODE = (TLAST_MODE != 0) ? TLAST_FORWARD : TLAST_COUNT;

    if (IN_WIDTH % SAMPLE_WIDTH != 0) begin : g_chk_in_width
        $error("IN_WIDTH must be a multiple of SAMPLE_WIDTH");
    end
    if (SAMPLE_WIDTH % 8 != 0) begin : g_chk_sample_width
        $error("SAMPLE_WIDTH must be a multiple of 8");
    end
    if (PACKET_SAMPLES < 1) begin : g_chk_packet
        $error("PACKET_SAMPLES must be at least 1");
    end
    if (IN_WIDTH > MAX_WORD_W) begin : g_chk_max_width
        $error("IN_WIDTH exceeds MAX_WORD_W of serializer_pkg");
    end

    logic [IN_WIDTH-1:0] hold_reg;
    logic                hold_last;
    logic                hold_valid;
    logic [LIDX_W-1:0]   lane_idx;
    logic [CNT_W-1:0]    sample_cnt;
    logic                last_lane;
    logic                out_hs;
    logic                in_hs;

    assign last_lane       = (lane_idx == LAST_LANE);
    assign out_hs          = hold_valid & m00_axis_tready;
    assign s00_axis_tready = ~hold_valid | (out_hs & last_lane);
    assign in_hs           = s00_axis_tvalid & s00_axis_tready;

    // Outputs are decoded purely from registered state, never from s00 inputs.
    assign m00_axis_tvalid = hold_valid;
    assign m00_axis_tstrb  = '1;
    assign m00_axis_tdata  = SAMPLE_WIDTH'(lane_select(MAX_WORD_W'(hold_reg), int'(lane_idx),
                                                       LANES, SAMPLE_WIDTH, ORDER));

    always_comb begin
        m00_axis_tlast = 1'b0;
        if (TMODE == TLAST_FORWARD) begin
            m00_axis_tlast = hold_valid & hold_last & last_lane;
        end else begin
            m00_axis_tlast = hold_valid & (sample_cnt == LAST_SAMPLE);
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            hold_reg   <= '0;
            hold_last  <= 1'b0;
            hold_valid <= 1'b0;
            lane_idx   <= '0;
        end else if (in_hs) begin
            hold_reg   <= s00_axis_tdata;
            hold_last  <= s00_axis_tlast;
            hold_valid <= 1'b1;
            lane_idx   <= '0;
        end else if (out_hs) begin
            if (last_lane) begin
                hold_valid <= 1'b0;
            end else begin
                lane_idx <= lane_idx + LIDX_W'(1);
            end
        end
    end

    // Sample counter runs across input beat boundaries and idle gaps.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            sample_cnt <= '0;
        end else if (TMODE == TLAST_COUNT && out_hs) begin
            if (sample_cnt == LAST_SAMPLE) begin
                sample_cnt <= '0;
            end else begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            packet_count <= '0;
            stall_count  <= '0;
        end else begin
            if (out_hs && m00_axis_tlast) begin
                packet_count <= packet_count + 16'd1;
            end
            if (hold_valid && !m00_axis_tready && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_axis_lane_serializer.sv
// Three serializer variants (default, MSB-first/24-sample packets, forwarded tlast) driven in lockstep.
module tb_axis_lane_serializer;

    localparam int LIMIT = 60000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_tvalid;
    logic [191:0]  s_tdata;
    logic          s_tlast;
    logic          m_tready;

    wire [2:0]        s_rdy;
    wire [2:0]        m_vld;
    wire [2:0]        m_last;
    wire [2:0][15:0]  m_dat;
    wire [2:0][1:0]   m_strb;
    wire [2:0][15:0]  pkt;
    wire [2:0][15:0]  stall;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int w_next  = 0;
    int n_out      [3];
    int exp_pkt    [3];
    int stall_seen [3];
    bit prev_stall [3];
    logic [15:0] prev_dat [3];
    logic        prev_last [3];
    int vld_cyc, rdy_in_vld, last_hs_cyc, first_acc_cyc;
    bit acc_recorded;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axis_lane_serializer u_def (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_rdy[0]),
        .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
        .m00_axis_tvalid(m_vld[0]), .m00_axis_tready(m_tready),
        .m00_axis_tdata(m_dat[0]), .m00_axis_tstrb(m_strb[0]), .m00_axis_tlast(m_last[0]),
        .packet_count(pkt[0]), .stall_count(stall[0])
    );

    axis_lane_serializer #(.LANE_ORDER(1), .PACKET_SAMPLES(24)) u_msb (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_rdy[1]),
        .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
        .m00_axis_tvalid(m_vld[1]), .m00_axis_tready(m_tready),
        .m00_axis_tdata(m_dat[1]), .m00_axis_tstrb(m_strb[1]), .m00_axis_tlast(m_last[1]),
        .packet_count(pkt[1]), .stall_count(stall[1])
    );

    axis_lane_serializer #(.TLAST_MODE(1)) u_fwd (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_rdy[2]),
        .s00_axis_tdata(s_tdata), .s00_axis_tlast(s_tlast),
        .m00_axis_tvalid(m_vld[2]), .m00_axis_tready(m_tready),
        .m00_axis_tdata(m_dat[2]), .m00_axis_tstrb(m_strb[2]), .m00_axis_tlast(m_last[2]),
        .packet_count(pkt[2]), .stall_count(stall[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Word w carries samples w*12+lane; every third word starting at 1 ends an input packet.
    function automatic logic [191:0] mk_word(input int w);
        logic [191:0] word;
        for (int l = 0; l < 12; l++) word[l*16 +: 16] = 16'(w * 12 + l);
        return word;
    endfunction

    function automatic logic tin(input int w);
        return (w % 3) == 1;
    endfunction

    function automatic logic [15:0] exp_dat(input int d, input int n);
        int j;
        j = n % 12;
        return 16'((n / 12) * 12 + ((d == 1) ? 11 - j : j));
    endfunction

    function automatic logic exp_last(input int d, input int n);
        if (d == 0) return (n % 6144) == 6143;
        if (d == 1) return (n % 24) == 23;
        return tin(n / 12) && (n % 12) == 11;
    endfunction

    task automatic reset_model();
        w_next = 0;
        for (int d = 0; d < 3; d++) begin
            n_out[d] = 0; exp_pkt[d] = 0; stall_seen[d] = 0; prev_stall[d] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("s_tready%0d", d), s_rdy[d],
                    !m_vld[d] || (m_tready && (n_out[d] % 12) == 11));
                if (prev_stall[d]) begin
                    chk($sformatf("stall_vld%0d", d), m_vld[d], 1'b1);
                    chk($sformatf("stall_dat%0d", d), m_dat[d], prev_dat[d]);
                    chk($sformatf("stall_last%0d", d), m_last[d], prev_last[d]);
                end
                prev_stall[d] = m_vld[d] && !m_tready;
                prev_dat[d]   = m_dat[d];
                prev_last[d]  = m_last[d];
                if (m_vld[d] && !m_tready) stall_seen[d]++;
                if (m_vld[d] && m_tready) begin
                    chk($sformatf("dat%0d", d), m_dat[d], exp_dat(d, n_out[d]));
                    chk($sformatf("last%0d", d), m_last[d], exp_last(d, n_out[d]));
                    if (exp_last(d, n_out[d])) exp_pkt[d]++;
                    if (d == 0) last_hs_cyc = cyc;
                    n_out[d]++;
                end
            end
            if (m_vld[0]) vld_cyc++;
            if (m_vld[0] && s_rdy[0]) rdy_in_vld++;
        end
    end

    task automatic run_words(input int nwords, input bit rnd);
        int  sent  = 0;
        int  guard = 0;
        bit  acc;
        while (sent < nwords && guard < LIMIT) begin
            if (!s_tvalid && (!rnd || $urandom_range(0, 3) != 0)) begin
                s_tvalid = 1'b1;
                s_tdata  = mk_word(w_next);
                s_tlast  = tin(w_next);
            end
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            acc = s_tvalid && s_rdy[0];
            if (acc && !acc_recorded) begin
                first_acc_cyc = cyc;
                acc_recorded  = 1'b1;
            end
            @(posedge clk); #1;
            if (acc) begin
                s_tvalid = 1'b0;
                w_next++;
                sent++;
            end
            guard++;
        end
        s_tvalid = 1'b0;
        while (m_vld != 3'b000 && guard < LIMIT) begin
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        m_tready = 1'b1;
        if (guard >= LIMIT) chk("timeout", 32'(guard), 32'(LIMIT - 1));
    endtask

    initial begin
        bit acc;
        int guard;
        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b1;
        acc_recorded = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_vld%0d", d), m_vld[d], 1'b0);
            chk($sformatf("rst_dat%0d", d), m_dat[d], 16'h0);
            chk($sformatf("rst_last%0d", d), m_last[d], 1'b0);
            chk($sformatf("rst_pkt%0d", d), pkt[d], 16'h0);
            chk($sformatf("rst_stall%0d", d), stall[d], 16'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("tready_after_rst", s_rdy[0], 1'b1);
        chk("tstrb", m_strb[0], 2'b11);
        @(posedge clk); #1;

        // Back-to-back words with an always-ready sink: 48 samples, no bubbles.
        vld_cyc = 0; rdy_in_vld = 0;
        run_words(4, 1'b0);
        chk("p1_vld_cycles", 32'(vld_cyc), 48);
        chk("p1_tready_in_stream", 32'(rdy_in_vld), 4);
        chk("p1_latency_span", 32'(last_hs_cyc - first_acc_cyc), 48);
        chk("p1_pkt_def", pkt[0], 16'd0);
        chk("p1_pkt_msb", pkt[1], 16'd2);
        chk("p1_pkt_fwd", pkt[2], 16'd1);

        // Random sink backpressure and input gaps over 1000 words.
        run_words(1000, 1'b1);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("p2_stall_count%0d", d), stall[d], 16'(stall_seen[d]));
            chk($sformatf("p2_pkt%0d", d), pkt[d], 16'(exp_pkt[d]));
        end
        chk("p2_pkt_msb_abs", pkt[1], 16'd502);

        // Reset arrives while lane 5 of a word is on the output.
        s_tvalid = 1'b1; s_tdata = mk_word(w_next); s_tlast = tin(w_next); m_tready = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            acc = s_rdy[0];
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 100);
        if (!acc) chk("rst_word_accept", 32'(acc), 1);
        s_tvalid = 1'b0;
        w_next++;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("mid_rst_vld%0d", d), m_vld[d], 1'b0);
            chk($sformatf("mid_rst_dat%0d", d), m_dat[d], 16'h0);
            chk($sformatf("mid_rst_last%0d", d), m_last[d], 1'b0);
            chk($sformatf("mid_rst_pkt%0d", d), pkt[d], 16'h0);
        end
        reset_model();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_tready", s_rdy[0], 1'b1);
        @(posedge clk); #1;
        run_words(2, 1'b0);
        chk("post_rst_pkt_def", pkt[0], 16'd0);
        chk("post_rst_pkt_msb", pkt[1], 16'd1);
        chk("post_rst_pkt_fwd", pkt[2], 16'd1);
        chk("post_rst_samples", 32'(n_out[0]), 24);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
